// File: rtl/exu_mul_ctrl.sv
// ---------------------------------------------------------------------------
// exu_mul_ctrl
//
// Sequencing stage around the EXU's 32x32 unsigned combinational array
// multiplier. RV32M multiply ops are converted to sign/magnitude on accept.
// The magnitudes are registered in S1 and drive the array. The unsigned
// product is sign-corrected and word-selected into S2, which is the output
// register. This is a 2-stage valid/ready pipeline with full throughput. It
// is in-order and stallable.
//
// Optional feature (build macro MUL_STAT_EN):
//   Adds the stat_count output, a 32-bit count of retired results.
//   The counter wraps at 2^32. Flush does not clear it.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous kill of all in-flight ops
//   in_valid/in_ready   issue-side handshake
//   in_op               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_rs1, in_rs2      multiplicand, multiplier
//   in_tag              destination tag carried with the op
//   mul_a, mul_x        operand magnitudes to the array (from S1 registers)
//   mul_product         64-bit unsigned product from the array
//   out_valid/out_ready result-side handshake
//   out_result, out_tag final rd value and its tag
//   stat_count          retired-result counter (MUL_STAT_EN only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module exu_mul_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [XLEN-1:0]     in_rs1,
    input  logic [XLEN-1:0]     in_rs2,
    input  logic [TAG_W-1:0]    in_tag,
    output logic [XLEN-1:0]     mul_a,
    output logic [XLEN-1:0]     mul_x,
    input  logic [2*XLEN-1:0]   mul_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
`ifdef MUL_STAT_EN
    output logic [TAG_W-1:0]    out_tag,
    output logic [31:0]         stat_count
`else
    output logic [TAG_W-1:0]    out_tag
`endif
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // Pipeline state
    logic               s1_valid;
    logic [XLEN-1:0]    s1_mag_a;
    logic [XLEN-1:0]    s1_mag_b;
    logic               s1_neg;
    logic               s1_hi_sel;
    logic [TAG_W-1:0]   s1_tag;
    logic               s2_valid;

    // Handshake
    logic s1_adv;
    logic s2_adv;
    logic accept;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid;
    assign mul_a     = s1_mag_a;
    assign mul_x     = s1_mag_b;

    // Operand decode: sign of each operand and its magnitude.
    // The magnitude of 0x80000000 is 0x80000000 itself, read as unsigned.
    logic               dec_sa;
    logic               dec_sb;
    logic [XLEN-1:0]    dec_mag_a;
    logic [XLEN-1:0]    dec_mag_b;

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        dec_sa    = 1'b0;
        dec_sb    = 1'b0;
        dec_mag_a = in_rs1;
        dec_mag_b = in_rs2;
        if (in_op == OP_MULH || in_op == OP_MULHSU)
            dec_sa = in_rs1[XLEN-1];
        if (in_op == OP_MULH)
            dec_sb = in_rs2[XLEN-1];
        if (dec_sa)
            dec_mag_a = -in_rs1;
        if (dec_sb)
            dec_mag_b = -in_rs2;
    end

    // Sign correction of the unsigned array product, then word select.
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    result_sel;

    always_comb begin
        prod_fix   = mul_product;
        result_sel = '0;
        if (s1_neg)
            prod_fix = ~mul_product + 1'b1;
        result_sel = s1_hi_sel ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    // S1: operand magnitudes feed the array straight from these registers.
    // NOTE: state uses non-blocking assignments, so every register samples
    // the pre-edge values regardless of block order.
    // NOTE: the data registers are reset as well as the valids. The operand
    // registers drive the array outputs, and those outputs must read zero
    // out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mag_a  <= '0;
            s1_mag_b  <= '0;
            s1_neg    <= 1'b0;
            s1_hi_sel <= 1'b0;
            s1_tag    <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (s1_adv)
                s1_valid <= accept;
            if (accept) begin
                s1_mag_a  <= dec_mag_a;
                s1_mag_b  <= dec_mag_b;
                s1_neg    <= dec_sa ^ dec_sb;
                s1_hi_sel <= (in_op != OP_MUL);
                s1_tag    <= in_tag;
            end
        end
    end

    // S2: the output register. Data only moves on a real transfer from S1,
    // so a stalled result and its tag stay put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s2_adv)
                s2_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                out_result <= result_sel;
                out_tag    <= s1_tag;
            end
        end
    end

`ifdef MUL_STAT_EN
    // Retirement counter. Flush does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stat_count <= '0;
        else if (out_valid && out_ready)
            stat_count <= stat_count + 32'd1;
    end
`endif

endmodule

// File: doc/exu_mul_ctrl.md
Name: exu_mul_ctrl

Overview:
- Sequencing stage wrapped around the EXU's 32x32 unsigned combinational array multiplier.
- Accepts RV32M multiply ops from issue and converts operands to sign and magnitude. Drives the magnitudes to the array from a register.
- Captures the 64-bit unsigned product, applies two's-complement correction, and selects the low or high word.
- 2-stage valid/ready pipeline: full throughput, in-order, stallable.

Parameters:
- XLEN, 32, operand width; only 32 supported (matches array).
- TAG_W, 5, width of the destination tag carried alongside each op.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous kill of all in-flight ops.
- in_valid  input  1  op presented.
- in_ready  output  1  stage can accept the op.
- in_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_rs1  input  32  multiplicand.
- in_rs2  input  32  multiplier.
- in_tag  input  TAG_W  destination tag.
- mul_a  output  32  magnitude of rs1 to array.
- mul_x  output  32  magnitude of rs2 to array.
- mul_product  input  64  unsigned product from array (combinational from mul_a/mul_x).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  32  final rd value.
- out_tag  output  TAG_W  tag of out_result.

Behaviour:
- Reset (async, rst=1):
  - s1_valid=0, s2_valid=0, out_valid=0, in_ready=1.
  - out_result=0, out_tag=0, mul_a=0, mul_x=0.
  - Reset mid-operation discards everything; no result is emitted for ops accepted before reset.
- Operand decode on accept:
  - sa = rs1[31] & (op==MULH | op==MULHSU).
  - sb = rs2[31] & (op==MULH).
  - mag_a = sa ? -rs1 : rs1, taken mod 2^32; 0x80000000 stays 0x80000000, which is the correct magnitude.
  - mag_b is formed the same way from rs2 and sb.
  - neg = sa ^ sb.
  - MUL uses sa=sb=0; the low 32 bits are sign-independent.
- Stage 1 (S1) register:
  - Holds mag_a, mag_b, neg, hi_sel=(op!=MUL), tag.
  - mul_a and mul_x are driven directly from S1 registers. No input-to-array combinational path.
- Stage 2 (S2) register:
  - p = neg ? (~mul_product + 1) : mul_product, 64-bit wrap.
  - out_result = hi_sel ? p[63:32] : p[31:0].
  - Tag is forwarded from S1.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Accept when in_valid & in_ready.
  - S1 loads when s1_adv. s1_valid_next = accept.
  - S2 loads from S1 when s2_adv. s2_valid_next = s1_valid.
  - out_valid = s2_valid.
- Latency and throughput:
  - Latency is 2 cycles from the accept edge to out_valid, with no stall.
  - Throughput is 1 op/cycle while out_ready=1.
- Stall: while out_valid & !out_ready, out_result and out_tag are held stable and S1 holds if valid.
- Simultaneous accept and retire in the same cycle is legal and loses nothing.
- in_ready depends on out_ready combinationally; this path is accepted.
- Flush:
  - Clears s1_valid and s2_valid next edge; data registers are don't-care.
  - Flush overrides accept in the same cycle: the op is dropped, and in_ready stays asserted as the handshake defines.
- Results leave in acceptance order, without exception.

Optional Feature:
- Macro: MUL_STAT_EN.
- Enabled:
  - Adds output port stat_count (32 bits), reset to 0.
  - Increments by 1 on every out_valid & out_ready cycle and wraps at 2^32.
  - Not cleared by flush.
- Disabled: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD: out_result=0xFFFFFFEB exactly 2 cycles after accept, out_tag echoes in_tag.
- MULH, 0x80000000 x 0x80000000: out_result=0x40000000. MULH, 0xFFFFFFFF x 0x00000001: out_result=0xFFFFFFFF.
- MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF: out_result=0xFFFFFFFF. MULHU, same operands: out_result=0xFFFFFFFE.
- Backpressure: 4 back-to-back ops with tags 1..4, out_ready=0 for 3 cycles.
  - in_ready drops once S1 and S2 are both full.
  - Results emerge tags 1,2,3,4 in order, each held stable while stalled; none lost or duplicated.
- Flush while S1 and S2 are valid, with in_valid=1: no out_valid on the following 2 cycles. The next op accepted after flush returns the correct result.
- Assert rst mid-stream with S2 valid: out_valid=0 immediately (async), all outputs 0. With MUL_STAT_EN, stat_count=0 and it counts 3 after 3 retirements.
